pic_intack_ctrl: RTL and testbench
==================================

PIC_INTACK_CTRL -- requirements
Module: pic_intack_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the max clk cycles between the first INTA and the second INTA (range 1..255).
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cpu_inta  input  1  CPU interrupt-acknowledge bus cycle active (level).
REQ-005 SHALL have port cpu_intr  output  1  interrupt request to CPU.
REQ-006 SHALL have port cpu_vector  output  8  vector returned on the second INTA.
REQ-007 SHALL have port cpu_vector_valid  output  1  cpu_vector valid.
REQ-008 SHALL have ports m_interrupt_do, m_slave_active  input  1 each, and m_interrupt_vector  input  8; all from the master PIC.
REQ-009 SHALL have port m_interrupt_done  output  1  one-cycle acknowledge to the master PIC.
REQ-010 SHALL have port s_interrupt_vector  input  8  from the slave PIC, and s_interrupt_done  output  1  one-cycle acknowledge to the slave PIC.
REQ-011 SHALL have port timeout_err  output  1  one-cycle pulse on an aborted acknowledge.

Function
REQ-012 SHALL register inta_last <= cpu_inta; inta_rise = cpu_inta & ~inta_last.
REQ-013 SHALL implement states IDLE, FIRST, WAIT2, VEC.
REQ-014 IDLE: cpu_intr <= m_interrupt_do; on inta_rise latch sel_slave <= m_slave_active, cpu_intr <= 0, go to FIRST.
REQ-015 FIRST: cpu_intr held 0; when cpu_inta == 0 go to WAIT2 and clear the timeout counter.
REQ-016 WAIT2: counter increments each cycle; on inta_rise latch cpu_vector <= sel_slave ? s_interrupt_vector : m_interrupt_vector, set cpu_vector_valid, and go to VEC.
REQ-017 On the WAIT2->VEC transition cycle: m_interrupt_done = 1 for exactly one cycle; s_interrupt_done = 1 in the same cycle only if sel_slave.
REQ-018 VEC: hold cpu_vector and cpu_vector_valid stable until cpu_inta == 0; then clear cpu_vector_valid and go to IDLE. cpu_vector retains its last value.
REQ-019 Latency: cpu_vector_valid rises 1 cycle after the second inta_rise; cpu_intr may reassert no earlier than the cycle after returning to IDLE.
REQ-020 Spurious: INTA while m_interrupt_do == 0 SHALL still run the full sequence and return the vector supplied by the PIC; no special vector is substituted.
REQ-021 Same-cycle inta_rise and m_interrupt_do fall: the acknowledge proceeds, and sel_slave uses that cycle's m_slave_active.
REQ-022 inta_rise outside IDLE or WAIT2 SHALL be ignored.
REQ-023 Done outputs SHALL never assert outside the WAIT2->VEC transition.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, cpu_intr 0, cpu_vector 8'h00, cpu_vector_valid 0, m_interrupt_done 0, s_interrupt_done 0, timeout_err 0, sel_slave 0, counter 0, inta_last 0.
REQ-025 Reset mid-sequence SHALL abort without issuing any done pulse; on release, a cpu_inta already high SHALL NOT count as a rising edge until it has been seen low.

Configuration
REQ-026 With PIC_INTACK_TIMEOUT_EN defined: if the counter reaches TIMEOUT_CYCLES in WAIT2 without inta_rise, return to IDLE, pulse timeout_err for one cycle, and issue no done pulses.
REQ-027 Without PIC_INTACK_TIMEOUT_EN: WAIT2 waits indefinitely, timeout_err is tied to 0, and no counter is present.

Structure
REQ-028 The state enum typedef and an 8-bit counter width constant SHALL live in shared package pic_pkg.
REQ-029 Single module; no sub-module is required (edge detect and FSM are inline).

Verification
REQ-030 Master IRQ: m_interrupt_do=1, m_slave_active=0, m_vector=8'h08; two INTA pulses -> cpu_vector=8'h08, m_interrupt_done one cycle, s_interrupt_done 0.
REQ-031 Cascade: m_slave_active=1, s_vector=8'h0A at the first INTA -> cpu_vector=8'h0A, both done outputs pulse in the same cycle.
REQ-032 Timeout (macro on, TIMEOUT_CYCLES=4): one INTA then idle 10 cycles -> timeout_err one pulse, no done pulses, state IDLE.
REQ-033 Timeout off: one INTA then idle 1000 cycles -> no pulse; a later second INTA completes normally.
REQ-034 rst_n low during WAIT2 -> all outputs 0 immediately; held-high INTA after release -> no acknowledge.
REQ-035 Back-to-back: second IRQ pending during VEC -> cpu_intr rises only after IDLE is re-entered.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC interrupt-acknowledge controller.
package pic_pkg;

  // Acknowledge sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_WAIT2 = 2'd2,
    ST_VEC   = 2'd3
  } pic_state_e;

  // Width of the inter-INTA timeout counter.
  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/pic_intack_ctrl.sv
// pic_intack_ctrl: sequences the two-cycle x86-style INTA handshake between
// the CPU and a master/slave PIC pair, returning the vector on the second
// INTA and acknowledging the PIC(s) that supplied it.
// Optional feature macro: PIC_INTACK_TIMEOUT_EN -- abort an acknowledge if
// the second INTA does not arrive within TIMEOUT_CYCLES clocks.
module pic_intack_ctrl
  import pic_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_inta,
  output logic       cpu_intr,
  output logic [7:0] cpu_vector,
  output logic       cpu_vector_valid,
  input  logic       m_interrupt_do,
  input  logic       m_slave_active,
  input  logic [7:0] m_interrupt_vector,
  output logic       m_interrupt_done,
  input  logic [7:0] s_interrupt_vector,
  output logic       s_interrupt_done,
  output logic       timeout_err
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("pic_intack_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

  pic_state_e state_q;
  logic       inta_last_q;
  logic       armed_q;      // cpu_inta has been seen low since reset
  logic       sel_slave_q;
  logic       cpu_intr_q;
  logic [7:0] vector_q;
  logic       valid_q;
  logic       m_done_q;
  logic       s_done_q;
  logic       inta_rise;

  // A rising INTA only counts once the line has been observed low after
  // reset, so an INTA already high at reset release is not an edge.
  assign inta_rise = cpu_inta & ~inta_last_q & armed_q;

`ifdef PIC_INTACK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tmo_q;

  // Next count value while waiting for the second INTA.
  always_comb begin
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Edge detector and acknowledge sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      inta_last_q <= 1'b0;
      armed_q     <= 1'b0;
      sel_slave_q <= 1'b0;
      cpu_intr_q  <= 1'b0;
      vector_q    <= 8'h00;
      valid_q     <= 1'b0;
      m_done_q    <= 1'b0;
      s_done_q    <= 1'b0;
`ifdef PIC_INTACK_TIMEOUT_EN
      cnt_q       <= {CNT_W{1'b0}};
      tmo_q       <= 1'b0;
`endif
    end else begin
      inta_last_q <= cpu_inta;
      armed_q     <= armed_q | ~cpu_inta;
      // Done and error outputs are single-cycle pulses.
      m_done_q    <= 1'b0;
      s_done_q    <= 1'b0;
`ifdef PIC_INTACK_TIMEOUT_EN
      tmo_q       <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          cpu_intr_q <= m_interrupt_do;
          if (inta_rise) begin
            // Cascade selection uses this cycle's m_slave_active even if
            // the request is withdrawn in the same cycle.
            sel_slave_q <= m_slave_active;
            cpu_intr_q  <= 1'b0;
            state_q     <= ST_FIRST;
          end
        end
        ST_FIRST: begin
          cpu_intr_q <= 1'b0;
          if (!cpu_inta) begin
            state_q <= ST_WAIT2;
`ifdef PIC_INTACK_TIMEOUT_EN
            cnt_q   <= {CNT_W{1'b0}};
`endif
          end
        end
        ST_WAIT2: begin
          cpu_intr_q <= 1'b0;
`ifdef PIC_INTACK_TIMEOUT_EN
          cnt_q <= cnt_d;
`endif
          if (inta_rise) begin
            vector_q <= sel_slave_q ? s_interrupt_vector : m_interrupt_vector;
            valid_q  <= 1'b1;
            m_done_q <= 1'b1;
            s_done_q <= sel_slave_q;
            state_q  <= ST_VEC;
          end
`ifdef PIC_INTACK_TIMEOUT_EN
          else if (cnt_d == TIMEOUT_C) begin
            tmo_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
`endif
        end
        ST_VEC: begin
          cpu_intr_q <= 1'b0;
          if (!cpu_inta) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          cpu_intr_q <= 1'b0;
          valid_q    <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_intr         = cpu_intr_q;
  assign cpu_vector       = vector_q;
  assign cpu_vector_valid = valid_q;
  assign m_interrupt_done = m_done_q;
  assign s_interrupt_done = s_done_q;

endmodule

// File: tb/tb_pic_intack_ctrl.sv
// Scoreboard bench for pic_intack_ctrl: stimulus pushes expected acknowledge
// events, a monitor pops and compares whenever the DUT presents one.
module tb_pic_intack_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_inta = 1'b0;
  logic       cpu_intr;
  logic [7:0] cpu_vector;
  logic       cpu_vector_valid;
  logic       m_interrupt_do = 1'b0;
  logic       m_slave_active = 1'b0;
  logic [7:0] m_interrupt_vector = 8'h00;
  logic       m_interrupt_done;
  logic [7:0] s_interrupt_vector = 8'h00;
  logic       s_interrupt_done;
  logic       timeout_err;

  typedef struct packed {
    logic       is_vec;
    logic [7:0] vec;
    logic       m_done;
    logic       s_done;
    logic       tmo;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  logic prev_valid = 1'b0;

  pic_intack_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cpu_inta           (cpu_inta),
    .cpu_intr           (cpu_intr),
    .cpu_vector         (cpu_vector),
    .cpu_vector_valid   (cpu_vector_valid),
    .m_interrupt_do     (m_interrupt_do),
    .m_slave_active     (m_slave_active),
    .m_interrupt_vector (m_interrupt_vector),
    .m_interrupt_done   (m_interrupt_done),
    .s_interrupt_vector (s_interrupt_vector),
    .s_interrupt_done   (s_interrupt_done),
    .timeout_err        (timeout_err)
  );

  always #5 clk = ~clk;

  // Monitor: any acknowledge-related activity must match the next expected event.
  always @(negedge clk) begin
    ev_t obs;
    ev_t e;
    obs.is_vec = cpu_vector_valid & ~prev_valid;
    obs.vec    = obs.is_vec ? cpu_vector : 8'h00;
    obs.m_done = m_interrupt_done;
    obs.s_done = s_interrupt_done;
    obs.tmo    = timeout_err;
    if (rst_n && (obs.is_vec || obs.m_done || obs.s_done || obs.tmo)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got vec_rise=%0b vec=%02h m_done=%0b s_done=%0b tmo=%0b, expected none",
                 obs.is_vec, obs.vec, obs.m_done, obs.s_done, obs.tmo);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++;
          $display("FAIL ack_event: got vec_rise=%0b vec=%02h m_done=%0b s_done=%0b tmo=%0b, expected vec_rise=%0b vec=%02h m_done=%0b s_done=%0b tmo=%0b",
                   obs.is_vec, obs.vec, obs.m_done, obs.s_done, obs.tmo,
                   e.is_vec, e.vec, e.m_done, e.s_done, e.tmo);
        end
      end
    end
    prev_valid = cpu_vector_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_vec(input logic [7:0] v, input logic sd);
    exp_q.push_back('{is_vec: 1'b1, vec: v, m_done: 1'b1, s_done: sd, tmo: 1'b0});
  endtask

  // First INTA pulse; leaves the DUT in WAIT2.
  task automatic first_inta();
    cpu_inta = 1'b1;
    tick(2);
    cpu_inta = 1'b0;
    tick(1);
  endtask

  // Second INTA pulse; checks vector hold during VEC and release after.
  task automatic second_inta(input logic [7:0] v);
    cpu_inta = 1'b1;
    tick(3);
    chk("vec_hold_valid", 32'(cpu_vector_valid), 32'd1);
    chk("vec_hold_value", 32'(cpu_vector), 32'(v));
    cpu_inta = 1'b0;
    tick(1);
    chk("valid_cleared", 32'(cpu_vector_valid), 32'd0);
    chk("vector_retained", 32'(cpu_vector), 32'(v));
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {22'd0, cpu_intr, cpu_vector, cpu_vector_valid}, 32'd0);
    chk({name, "_done"}, {29'd0, m_interrupt_done, s_interrupt_done, timeout_err}, 32'd0);
  endtask

  initial begin
    m_interrupt_vector = 8'h08;
    s_interrupt_vector = 8'h0A;
    m_interrupt_do     = 1'b1;
    tick(2);
    chk_all_zero("reset_state");
    rst_n = 1'b1;
    tick(2);
    chk("intr_follow", 32'(cpu_intr), 32'd1);

    // Master-only interrupt.
    push_vec(8'h08, 1'b0);
    first_inta();
    chk("intr_low_wait2", 32'(cpu_intr), 32'd0);
    m_interrupt_do = 1'b0;
    second_inta(8'h08);
    tick(2);
    chk("intr_idle_no_req", 32'(cpu_intr), 32'd0);

    // Cascade through the slave; slave select latched at the first INTA.
    m_interrupt_do = 1'b1;
    m_slave_active = 1'b1;
    tick(1);
    push_vec(8'h0A, 1'b1);
    first_inta();
    m_slave_active = 1'b0;
    m_interrupt_do = 1'b0;
    second_inta(8'h0A);

    // Spurious: no request, vector still comes from the master.
    m_interrupt_vector = 8'h0F;
    tick(1);
    push_vec(8'h0F, 1'b0);
    first_inta();
    second_inta(8'h0F);

    // Request withdrawn on the same cycle as INTA rise, slave active then.
    m_interrupt_do = 1'b1;
    tick(2);
    s_interrupt_vector = 8'h5C;
    push_vec(8'h5C, 1'b1);
    cpu_inta = 1'b1;
    m_interrupt_do = 1'b0;
    m_slave_active = 1'b1;
    tick(1);
    m_slave_active = 1'b0;
    chk("intr_low_after_rise", 32'(cpu_intr), 32'd0);
    tick(1);
    cpu_inta = 1'b0;
    tick(1);
    second_inta(8'h5C);

    // Back-to-back: a new request pending during VEC waits for IDLE.
    m_interrupt_vector = 8'h21;
    m_interrupt_do = 1'b1;
    tick(2);
    push_vec(8'h21, 1'b0);
    first_inta();
    cpu_inta = 1'b1;
    tick(1);
    chk("b2b_intr_vec1", 32'(cpu_intr), 32'd0);
    tick(1);
    chk("b2b_intr_vec2", 32'(cpu_intr), 32'd0);
    cpu_inta = 1'b0;
    tick(1);
    chk("b2b_intr_idle_entry", 32'(cpu_intr), 32'd0);
    tick(1);
    chk("b2b_intr_reassert", 32'(cpu_intr), 32'd1);
    push_vec(8'h21, 1'b0);
    first_inta();
    m_interrupt_do = 1'b0;
    second_inta(8'h21);

`ifdef PIC_INTACK_TIMEOUT_EN
    // Missing second INTA aborts after TIMEOUT_CYCLES.
    m_interrupt_do = 1'b1;
    tick(1);
    exp_q.push_back('{is_vec: 1'b0, vec: 8'h00, m_done: 1'b0, s_done: 1'b0, tmo: 1'b1});
    first_inta();
    tick(10);
    chk("tmo_no_valid", 32'(cpu_vector_valid), 32'd0);
    chk("tmo_back_idle", 32'(cpu_intr), 32'd1);
    push_vec(8'h21, 1'b0);
    first_inta();
    m_interrupt_do = 1'b0;
    second_inta(8'h21);
`else
    // No timeout: a long gap before the second INTA still completes.
    m_interrupt_vector = 8'h44;
    m_interrupt_do = 1'b1;
    tick(1);
    first_inta();
    m_interrupt_do = 1'b0;
    tick(1000);
    chk("no_tmo_pulse", 32'(timeout_err), 32'd0);
    push_vec(8'h44, 1'b0);
    second_inta(8'h44);
`endif

    // Reset during WAIT2, INTA raised while in reset and held after release.
    m_interrupt_vector = 8'h33;
    m_interrupt_do = 1'b1;
    tick(1);
    first_inta();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_wait2");
    cpu_inta = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("held_inta_no_ack", 32'(cpu_vector_valid), 32'd0);
    chk("held_inta_intr_idle", 32'(cpu_intr), 32'd1);
    cpu_inta = 1'b0;
    tick(2);

    // Reset during VEC clears the presented vector immediately.
    push_vec(8'h33, 1'b0);
    first_inta();
    cpu_inta = 1'b1;
    tick(1);
    #5 rst_n = 1'b0;
    #1 chk_all_zero("rst_vec");
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("rst_vec_no_ack", 32'(cpu_vector_valid), 32'd0);
    cpu_inta = 1'b0;
    tick(2);

    // Recovery after reset: a normal acknowledge works again.
    push_vec(8'h33, 1'b0);
    first_inta();
    m_interrupt_do = 1'b0;
    second_inta(8'h33);

    tick(5);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
